// File: rtl/bullet_collider.sv
// bullet_collider: frame-synchronous collision scanner and HP keeper.
// On each frame tick it walks the bullet store's collision read port one
// entry at a time. It pulses is_collide for every bullet that hits the
// heart box, and applies damage or healing to a saturating HP register.
// Optional feature macro: BULLET_IFRAME_EN (invincibility frames after damage).
module bullet_collider #(
  parameter int NUM_BULLETS  = 8,
  parameter int IDX_W        = 3,
  parameter int HP_MAX       = 20,
  parameter int DAMAGE       = 4,
  parameter int HEAL         = 2,
  parameter int IFRAME_TICKS = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic [15:0]      player_pos,
  input  logic [15:0]      player_size,
  input  logic             player_moving,
  output logic [IDX_W-1:0] index,
  input  logic [15:0]      bullet_pos,
  input  logic [15:0]      bullet_size,
  input  logic [2:0]       bullet_color,
  input  logic             bullet_render,
  output logic             is_collide,
  output logic [7:0]       hp,
  output logic             busy,
  output logic             scan_done,
  output logic             game_over
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EVAL  = 3'd2,
    HIT   = 3'd3,
    DONE  = 3'd4,
    OVER  = 3'd5
  } state_e;

  localparam logic [2:0] COLOR_WHITE = 3'b000;
  localparam logic [2:0] COLOR_GREEN = 3'b001;
  localparam logic [2:0] COLOR_BLUE  = 3'b010;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [7:0]       hp_q, hp_d;

  logic [15:0]      bulPos_q, bulSize_q;
  logic [2:0]       bulColor_q;
  logic             bulRender_q;

  logic             isLast;
  logic             overlap;
  logic             colorWhite, colorGreen, colorBlue;
  logic             damaging;
  logic             hitQual;
  logic             iframeClear;
  logic             hitIsGreen;
  logic [8:0]       healSum;
  logic [7:0]       hpHealed, hpDamaged, hpHit;

  logic [8:0]       pxEnd, pyEnd, bxEnd, byEnd;
  logic             sizesNonZero;

  assign isLast = (index_q == IDX_W'(NUM_BULLETS - 1));

  // Box overlap on the fetched bullet; 9-bit right/bottom edges cannot wrap.
  always_comb begin
    pxEnd = {1'b0, player_pos[15:8]} + {1'b0, player_size[15:8]};
    pyEnd = {1'b0, player_pos[7:0]}  + {1'b0, player_size[7:0]};
    bxEnd = {1'b0, bulPos_q[15:8]}   + {1'b0, bulSize_q[15:8]};
    byEnd = {1'b0, bulPos_q[7:0]}    + {1'b0, bulSize_q[7:0]};
    sizesNonZero = (player_size[15:8] != 8'd0) && (player_size[7:0] != 8'd0) &&
                   (bulSize_q[15:8] != 8'd0)   && (bulSize_q[7:0] != 8'd0);
    overlap = sizesNonZero &&
              ({1'b0, player_pos[15:8]} < bxEnd) &&
              ({1'b0, bulPos_q[15:8]}   < pxEnd) &&
              ({1'b0, player_pos[7:0]}  < byEnd) &&
              ({1'b0, bulPos_q[7:0]}    < pyEnd);
  end

  assign colorWhite = (bulColor_q == COLOR_WHITE);
  assign colorGreen = (bulColor_q == COLOR_GREEN);
  assign colorBlue  = (bulColor_q == COLOR_BLUE);
  assign damaging   = colorWhite | (colorBlue & player_moving);
  assign hitQual    = bulRender_q & overlap & (colorGreen | (damaging & iframeClear));

  // HP after the hit currently being retired: saturating heal or clamped damage.
  always_comb begin
    hitIsGreen = colorGreen;
    healSum    = {1'b0, hp_q} + 9'(HEAL);
    hpHealed   = (healSum > 9'(HP_MAX)) ? 8'(HP_MAX) : healSum[7:0];
    hpDamaged  = (hp_q > 8'(DAMAGE)) ? (hp_q - 8'(DAMAGE)) : 8'd0;
    hpHit      = hitIsGreen ? hpHealed : hpDamaged;
  end

`ifdef BULLET_IFRAME_EN
  localparam int IF_W = $clog2(IFRAME_TICKS + 1);

  logic [IF_W-1:0] iframe_q, iframe_d;

  // Invincibility counter: reloads on a damaging hit, otherwise counts frame ticks down.
  always_comb begin
    iframe_d = iframe_q;
    if (frame_tick && (iframe_q != '0)) begin
      iframe_d = iframe_q - 1'b1;
    end
    if ((state_q == HIT) && !hitIsGreen) begin
      iframe_d = IF_W'(IFRAME_TICKS);
    end
  end

  // Invincibility counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      iframe_q <= '0;
    end else begin
      iframe_q <= iframe_d;
    end
  end

  assign iframeClear = (iframe_q == '0);
`else
  assign iframeClear = 1'b1;
`endif

  // Next-state logic: walks the entries, inserting a HIT cycle for each hit.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = FETCH;
          index_d = '0;
        end
      end
      FETCH: state_d = EVAL;
      EVAL: begin
        if (hitQual) begin
          state_d = HIT;
        end else if (isLast) begin
          state_d = DONE;
        end else begin
          state_d = FETCH;
          index_d = index_q + 1'b1;
        end
      end
      HIT: begin
        if (hpHit == 8'd0) begin
          state_d = OVER;
        end else if (isLast) begin
          state_d = DONE;
        end else begin
          state_d = FETCH;
          index_d = index_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        index_d = '0;
      end
      OVER:    state_d = OVER;
      default: state_d = IDLE;
    endcase
  end

  assign hp_d = (state_q == HIT) ? hpHit : hp_q;

  // State, index and HP registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      index_q <= '0;
      hp_q    <= 8'(HP_MAX);
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      hp_q    <= hp_d;
    end
  end

  // Capture the selected bullet during FETCH so EVAL sees stable values.
  always_ff @(posedge clk) begin
    if (reset) begin
      bulPos_q    <= '0;
      bulSize_q   <= '0;
      bulColor_q  <= '0;
      bulRender_q <= 1'b0;
    end else if (state_q == FETCH) begin
      bulPos_q    <= bullet_pos;
      bulSize_q   <= bullet_size;
      bulColor_q  <= bullet_color;
      bulRender_q <= bullet_render;
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    is_collide = (state_q == HIT);
    busy       = (state_q == FETCH) || (state_q == EVAL) ||
                 (state_q == HIT)   || (state_q == DONE);
    scan_done  = (state_q == DONE);
    game_over  = (state_q == OVER);
  end

  assign index = index_q;
  assign hp    = hp_q;

endmodule

// File: tb/tb_bullet_collider.sv
// tb_bullet_collider: directed and randomized frames for bullet_collider,
// checked against a per-frame behavioural model of the scan.
module tb_bullet_collider;

  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic [15:0] player_pos;
  logic [15:0] player_size;
  logic        player_moving;
  logic [2:0]  index;
  logic [15:0] bullet_pos;
  logic [15:0] bullet_size;
  logic [2:0]  bullet_color;
  logic        bullet_render;
  logic        is_collide;
  logic [7:0]  hp;
  logic        busy;
  logic        scan_done;
  logic        game_over;

  logic [15:0] sPos[NB];
  logic [15:0] sSize[NB];
  logic [2:0]  sColor[NB];
  logic        sRender[NB];

  int checks = 0;
  int errors = 0;

  int mHp;
  bit mOver;
  int mIframe;
  int expHits[$];
  int expBusy;
  int expDoneAt;
  int obsHits[$];
  int obsBusy;
  int obsDoneAt;

  always #5 clk = ~clk;

  assign bullet_pos    = sPos[index];
  assign bullet_size   = sSize[index];
  assign bullet_color  = sColor[index];
  assign bullet_render = sRender[index];

  bullet_collider dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .player_pos   (player_pos),
    .player_size  (player_size),
    .player_moving(player_moving),
    .index        (index),
    .bullet_pos   (bullet_pos),
    .bullet_size  (bullet_size),
    .bullet_color (bullet_color),
    .bullet_render(bullet_render),
    .is_collide   (is_collide),
    .hp           (hp),
    .busy         (busy),
    .scan_done    (scan_done),
    .game_over    (game_over)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clearStore();
    for (int i = 0; i < NB; i++) begin
      sPos[i] = 16'h0000; sSize[i] = 16'h0404; sColor[i] = 3'd0; sRender[i] = 1'b0;
    end
  endtask

  task automatic setBullet(input int i, input int x, input int y, input int w, input int h,
                           input int c, input bit r);
    sPos[i]    = {8'(x), 8'(y)};
    sSize[i]   = {8'(w), 8'(h)};
    sColor[i]  = 3'(c);
    sRender[i] = r;
  endtask

  task automatic setPlayer(input int x, input int y, input int w, input int h, input bit mv);
    player_pos    = {8'(x), 8'(y)};
    player_size   = {8'(w), 8'(h)};
    player_moving = mv;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mHp = 20; mOver = 1'b0; mIframe = 0;
  endtask

  function automatic bit modelOverlap(input int i);
    int px, py, pw, ph, bx, by, bw, bh;
    px = player_pos[15:8]; py = player_pos[7:0];
    pw = player_size[15:8]; ph = player_size[7:0];
    bx = sPos[i][15:8]; by = sPos[i][7:0];
    bw = sSize[i][15:8]; bh = sSize[i][7:0];
    if (pw == 0 || ph == 0 || bw == 0 || bh == 0) return 1'b0;
    return (px < bx + bw) && (bx < px + pw) && (py < by + bh) && (by < py + ph);
  endfunction

  // Expected outcome of one frame, computed from the scan rules before it runs.
  task automatic modelFrame();
    int lastIdx;
    bit green, dmg;
    expHits.delete();
    if (mOver) begin
      expBusy = 0; expDoneAt = -1;
      return;
    end
`ifdef BULLET_IFRAME_EN
    if (mIframe > 0) mIframe--;
`endif
    lastIdx = NB - 1;
    for (int i = 0; i < NB; i++) begin
      if (sRender[i] && modelOverlap(i)) begin
        green = (sColor[i] == 3'd1);
        dmg   = (sColor[i] == 3'd0) || (sColor[i] == 3'd2 && player_moving);
`ifdef BULLET_IFRAME_EN
        if (mIframe > 0) dmg = 1'b0;
`endif
        if (green || dmg) begin
          expHits.push_back(i);
          if (green) mHp = (mHp + 2 > 20) ? 20 : mHp + 2;
          else begin
            mHp = (mHp - 4 < 0) ? 0 : mHp - 4;
`ifdef BULLET_IFRAME_EN
            mIframe = 30;
`endif
          end
          if (mHp == 0) begin
            mOver = 1'b1; lastIdx = i;
            break;
          end
        end
      end
    end
    expBusy   = 2 * (lastIdx + 1) + expHits.size() + (mOver ? 0 : 1);
    expDoneAt = mOver ? -1 : expBusy;
  endtask

  // Issue one frame tick and record the scan, retiring bullets on each pulse.
  task automatic applyStimulus();
    obsHits.delete(); obsBusy = 0; obsDoneAt = -1;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge clk);
      if (busy) obsBusy++;
      if (is_collide) begin
        obsHits.push_back(int'(index));
        sRender[index] = 1'b0;
      end
      if (scan_done) begin obsDoneAt = c; break; end
      if (game_over) break;
    end
  endtask

  task automatic runFrame(input string tag);
    modelFrame();
    applyStimulus();
    checkOutput({tag, ".hits"}, obsHits.size(), expHits.size());
    for (int k = 0; k < expHits.size() && k < obsHits.size(); k++)
      checkOutput($sformatf("%s.hitIdx%0d", tag, k), obsHits[k], expHits[k]);
    checkOutput({tag, ".busyCycles"}, obsBusy, expBusy);
    checkOutput({tag, ".doneAt"}, obsDoneAt, expDoneAt);
    @(negedge clk);
    checkOutput({tag, ".hp"}, hp, mHp);
    checkOutput({tag, ".gameOver"}, game_over, mOver);
    checkOutput({tag, ".busyAfter"}, busy, 0);
    if (!mOver) checkOutput({tag, ".indexAfter"}, index, 0);
  endtask

  initial begin
    int doneCount, pulseCount, px, py;
    reset = 1'b0; frame_tick = 1'b0;
    clearStore();
    setPlayer(50, 50, 16, 16, 1'b0);

    // Step 1: reset values.
    doReset();
    checkOutput("reset.hp", hp, 20);
    checkOutput("reset.index", index, 0);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.isCollide", is_collide, 0);
    checkOutput("reset.scanDone", scan_done, 0);
    checkOutput("reset.gameOver", game_over, 0);

    // Step 2: empty frame, then a tick while busy must be dropped.
    runFrame("empty");
    doneCount = 0;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (scan_done) doneCount++;
    end
    checkOutput("drop.scanDoneCount", doneCount, 1);
    checkOutput("drop.busyIdle", busy, 0);

    // Step 3: white bullet at index 2.
    setBullet(2, 60, 60, 4, 4, 0, 1'b1);
    runFrame("white2");
`ifndef BULLET_IFRAME_EN
    checkOutput("white2.hpConst", hp, 16);

    // Step 4: blue needs movement.
    setBullet(3, 55, 55, 4, 4, 2, 1'b1);
    runFrame("blueStill");
    player_moving = 1'b1;
    runFrame("blueMoving");
    checkOutput("blueMoving.hpConst", hp, 12);
    player_moving = 1'b0;
`endif

    // Step 5: green heal, and touching edges that must not hit.
    clearStore();
    setBullet(0, 52, 52, 2, 2, 1, 1'b1);
    setBullet(1, 66, 50, 4, 4, 0, 1'b1);
    setBullet(4, 50, 66, 4, 4, 0, 1'b1);
    setBullet(5, 46, 50, 4, 4, 0, 1'b1);
    runFrame("greenTouch");
    doReset();
    clearStore();
    setBullet(7, 60, 52, 3, 3, 1, 1'b1);
    runFrame("greenSat");
    checkOutput("greenSat.hpConst", hp, 20);

    // Step 6: five white hits end the game; later ticks are ignored.
    clearStore();
    for (int i = 0; i < 6; i++) setBullet(i, 51 + i, 53, 5, 5, 0, 1'b1);
    runFrame("fiveWhite");
`ifndef BULLET_IFRAME_EN
    checkOutput("fiveWhite.hpConst", hp, 0);
    checkOutput("fiveWhite.gameOverConst", game_over, 1);
`endif
    runFrame("afterOver");
    doReset();
    checkOutput("reReset.hp", hp, 20);
    checkOutput("reReset.gameOver", game_over, 0);

    // Step 7: reset in the middle of a scan suppresses all pulses.
    clearStore();
    setBullet(6, 55, 55, 4, 4, 0, 1'b1);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    pulseCount = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (is_collide || scan_done || busy) pulseCount++;
    end
    checkOutput("midReset.activity", pulseCount, 0);
    checkOutput("midReset.hp", hp, 20);
    mHp = 20; mOver = 1'b0; mIframe = 0;

    // Step 8: randomized frames against the model.
    for (int f = 0; f < 30; f++) begin
      px = $urandom_range(40, 200);
      py = $urandom_range(40, 200);
      setPlayer(px, py, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 20),
                $urandom_range(1, 20), 1'($urandom_range(0, 1)));
      for (int i = 0; i < NB; i++)
        setBullet(i, px + $urandom_range(0, 40) - 20, py + $urandom_range(0, 40) - 20,
                  $urandom_range(0, 8), $urandom_range(0, 8),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(3, 7) : $urandom_range(0, 2),
                  ($urandom_range(0, 3) != 0));
      runFrame($sformatf("rand%0d", f));
      if (mOver) doReset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
